// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the player movement logic.
//   dir_t          : facing / request direction (UP=0, DOWN=1, LEFT=2, RIGHT=3)
//   mover_state_t  : player_mover FSM states (IDLE, HOP)
//   SCREEN_W_PX/H  : default playfield size in pixels
//   REPEAT_CNT_W   : width of the auto-repeat frame counter
//   pick_dir       : resolves a multi-bit request vector to one direction
// -----------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOP  = 1'b1
    } mover_state_t;

    localparam int SCREEN_W_PX  = 640;
    localparam int SCREEN_H_PX  = 480;
    localparam int REPEAT_CNT_W = 8;

    // Request bit order is 0 left, 1 down, 2 up, 3 right; when several bits
    // are set the winner is up > down > left > right.
    function automatic dir_t pick_dir(input logic [3:0] req);
        if (req[2])      return UP;
        else if (req[1]) return DOWN;
        else if (req[0]) return LEFT;
        else             return RIGHT;
    endfunction

endpackage

// File: rtl/repeat_timer.sv
// -----------------------------------------------------------------------------
// repeat_timer
// Auto-repeat generator for a held direction key. While exactly one dir_level
// bit is held it emits a one-cycle pulse on that bit REPEAT_DELAY frame ticks
// after the press, then every REPEAT_RATE frame ticks.
// Only instantiated by player_mover when PLAYER_MOVER_REPEAT_EN is defined.
// Ports:
//   clk, reset   : clock, synchronous active-high reset (also used for respawn)
//   enable       : counting is held in restart while low
//   frame_tick   : one-cycle pulse per video frame
//   dir_level[4] : debounced held levels
//   rep_tick[4]  : registered repeat pulses, same bit order as dir_level
// -----------------------------------------------------------------------------
module repeat_timer
    import game_pkg::*;
#(
    parameter int REPEAT_DELAY = 12,
    parameter int REPEAT_RATE  = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_tick,
    input  logic [3:0] dir_level,
    output logic [3:0] rep_tick
);

    logic [3:0]              prev_level;
    logic [REPEAT_CNT_W-1:0] cnt;
    logic [REPEAT_CNT_W-1:0] limit;
    logic                    repeating;

    // First pulse waits the long delay, later pulses use the short rate.
    assign limit = repeating ? REPEAT_CNT_W'(REPEAT_RATE) : REPEAT_CNT_W'(REPEAT_DELAY);

    // Any change of the held keys, a chord, or a disable restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_level <= 4'b0000;
            cnt        <= '0;
            repeating  <= 1'b0;
            rep_tick   <= 4'b0000;
        end else begin
            prev_level <= dir_level;
            rep_tick   <= 4'b0000;
            if (!enable || (dir_level != prev_level) || !$onehot(dir_level)) begin
                cnt       <= '0;
                repeating <= 1'b0;
            end else if (frame_tick) begin
                if ((cnt + 1'b1) == limit) begin
                    rep_tick  <= dir_level;
                    cnt       <= '0;
                    repeating <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/player_mover.sv
// -----------------------------------------------------------------------------
// player_mover
// Grid-hop movement controller for the player sprite. Direction pulses start
// cell-sized hops that advance STEP_PX pixels per frame_tick; one further
// request may be buffered during a hop and is taken at landing.
// Optional feature macro: PLAYER_MOVER_REPEAT_EN (auto-repeat from dir_level).
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   enable            : high while the game is PLAYING
//   frame_tick        : one-cycle pulse per video frame
//   dir_tick[4]       : press pulses (0 left, 1 down, 2 up, 3 right)
//   dir_level[4]      : held levels, same order (used only with auto-repeat)
//   init_x, init_y    : spawn position
//   respawn           : return to spawn, overrides everything else
//   pos_x, pos_y      : current top-left pixel position
//   direction[2]      : facing, UP=0 DOWN=1 LEFT=2 RIGHT=3
//   moving            : high while hopping
//   hop_done          : one-cycle pulse after a hop lands
//   reached_end       : settled on the goal row
// -----------------------------------------------------------------------------
module player_mover
    import game_pkg::*;
#(
    parameter int COORD_W      = 10,
    parameter int CELL         = 32,
    parameter int STEP_PX      = 4,
    parameter int SCREEN_W     = SCREEN_W_PX,
    parameter int SCREEN_H     = SCREEN_H_PX,
    parameter int GOAL_Y       = 15,
    parameter int REPEAT_DELAY = 12,
    parameter int REPEAT_RATE  = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               frame_tick,
    input  logic [3:0]         dir_tick,
    input  logic [3:0]         dir_level,
    input  logic [COORD_W-1:0] init_x,
    input  logic [COORD_W-1:0] init_y,
    input  logic               respawn,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic [1:0]         direction,
    output logic               moving,
    output logic               hop_done,
    output logic               reached_end
);

    if ((CELL % STEP_PX) != 0) begin : g_bad_step
        $error("player_mover: CELL must be a multiple of STEP_PX");
    end
    if ((REPEAT_DELAY < 1) || (REPEAT_RATE < 1)) begin : g_bad_repeat
        $error("player_mover: repeat timing must be at least one frame");
    end

    localparam logic [COORD_W-1:0] CELL_C  = COORD_W'(CELL);
    localparam logic [COORD_W-1:0] STEP_C  = COORD_W'(STEP_PX);
    localparam logic [COORD_W-1:0] GOAL_C  = COORD_W'(GOAL_Y);
    localparam logic [COORD_W:0]   CELL_X  = (COORD_W+1)'(CELL);
    localparam logic [COORD_W:0]   CELL2_X = (COORD_W+1)'(2 * CELL);
    localparam logic [COORD_W:0]   SCR_W_X = (COORD_W+1)'(SCREEN_W);
    localparam logic [COORD_W:0]   SCR_H_X = (COORD_W+1)'(SCREEN_H);

    mover_state_t       state;
    dir_t               dir_q;
    dir_t               buf_dir;
    logic               buf_valid;
    logic [COORD_W-1:0] tgt_x;
    logic [COORD_W-1:0] tgt_y;

    logic [3:0]         req_raw;
    logic [3:0]         req_vec;
    logic               has_req;
    dir_t               eval_dir;
    logic               eval_legal;
    logic [COORD_W-1:0] nx;
    logic [COORD_W-1:0] ny;
    logic [COORD_W:0]   ext_x;
    logic [COORD_W:0]   ext_y;
    logic               at_target;

`ifdef PLAYER_MOVER_REPEAT_EN
    logic [3:0] rep_tick;

    repeat_timer #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_repeat (
        .clk        (clk),
        .reset      (reset || respawn),
        .enable     (enable),
        .frame_tick (frame_tick),
        .dir_level  (dir_level),
        .rep_tick   (rep_tick)
    );

    assign req_raw = dir_tick | rep_tick;
`else
    logic unused_level;
    assign unused_level = ^dir_level;
    assign req_raw      = dir_tick;
`endif

    assign req_vec   = enable ? req_raw : 4'b0000;
    assign has_req   = |req_vec;
    assign ext_x     = {1'b0, pos_x};
    assign ext_y     = {1'b0, pos_y};
    assign at_target = (pos_x == tgt_x) && (pos_y == tgt_y);
    assign direction = dir_q;

    // The move under consideration is a fresh request if there is one,
    // otherwise the buffered one; legality is judged from the current
    // position at one extra bit so edge sums cannot wrap.
    always_comb begin
        eval_dir   = has_req ? pick_dir(req_vec) : buf_dir;
        eval_legal = 1'b0;
        nx         = pos_x;
        ny         = pos_y;
        case (eval_dir)
            UP: begin
                eval_legal = (ext_y >= CELL_X);
                ny         = pos_y - CELL_C;
            end
            DOWN: begin
                eval_legal = ((ext_y + CELL2_X) <= SCR_H_X);
                ny         = pos_y + CELL_C;
            end
            LEFT: begin
                eval_legal = (ext_x >= CELL_X);
                nx         = pos_x - CELL_C;
            end
            RIGHT: begin
                eval_legal = ((ext_x + CELL2_X) <= SCR_W_X);
                nx         = pos_x + CELL_C;
            end
            default: ;
        endcase
    end

    // Landing is recognised the cycle after the last step puts pos on the
    // target, so a buffered hop chains without ever passing through IDLE.
    always_ff @(posedge clk) begin
        if (reset || respawn) begin
            state       <= IDLE;
            pos_x       <= init_x;
            pos_y       <= init_y;
            tgt_x       <= init_x;
            tgt_y       <= init_y;
            dir_q       <= UP;
            buf_dir     <= UP;
            buf_valid   <= 1'b0;
            moving      <= 1'b0;
            hop_done    <= 1'b0;
            reached_end <= 1'b0;
        end else begin
            hop_done <= 1'b0;
            case (state)
                IDLE: begin
                    buf_valid   <= 1'b0;
                    reached_end <= (pos_y <= GOAL_C);
                    if (has_req) begin
                        dir_q <= eval_dir;
                        if (eval_legal) begin
                            tgt_x       <= nx;
                            tgt_y       <= ny;
                            state       <= HOP;
                            moving      <= 1'b1;
                            reached_end <= 1'b0;
                        end
                    end
                end
                HOP: begin
                    reached_end <= 1'b0;
                    if (at_target) begin
                        hop_done  <= 1'b1;
                        buf_valid <= 1'b0;
                        if (has_req || (enable && buf_valid)) begin
                            dir_q <= eval_dir;
                            if (eval_legal) begin
                                tgt_x <= nx;
                                tgt_y <= ny;
                            end else begin
                                state  <= IDLE;
                                moving <= 1'b0;
                            end
                        end else begin
                            state  <= IDLE;
                            moving <= 1'b0;
                        end
                    end else begin
                        if (frame_tick) begin
                            if (pos_x != tgt_x)
                                pos_x <= (pos_x < tgt_x) ? pos_x + STEP_C : pos_x - STEP_C;
                            else
                                pos_y <= (pos_y < tgt_y) ? pos_y + STEP_C : pos_y - STEP_C;
                        end
                        if (!enable) begin
                            buf_valid <= 1'b0;
                        end else if (has_req) begin
                            buf_valid <= 1'b1;
                            buf_dir   <= eval_dir;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_player_mover.sv
// -----------------------------------------------------------------------------
// tb_player_mover
// Directed self-checking bench for player_mover with default parameters.
// Inputs are driven 1 ns after a rising edge and outputs are sampled at the
// same point, so each applyStimulus call covers exactly one clock edge.
// -----------------------------------------------------------------------------
module tb_player_mover;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       frame_tick;
    logic [3:0] dir_tick;
    logic [3:0] dir_level;
    logic [9:0] init_x;
    logic [9:0] init_y;
    logic       respawn;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [1:0] direction;
    logic       moving;
    logic       hop_done;
    logic       reached_end;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] K_LEFT  = 4'b0001;
    localparam logic [3:0] K_DOWN  = 4'b0010;
    localparam logic [3:0] K_UP    = 4'b0100;
    localparam logic [3:0] K_RIGHT = 4'b1000;

    player_mover dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .frame_tick  (frame_tick),
        .dir_tick    (dir_tick),
        .dir_level   (dir_level),
        .init_x      (init_x),
        .init_y      (init_y),
        .respawn     (respawn),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .direction   (direction),
        .moving      (moving),
        .hop_done    (hop_done),
        .reached_end (reached_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
            $error("[TB] %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive pulses for one clock edge, then release them.
    task automatic applyStimulus(input logic [3:0] ticks, input logic ft, input logic rs);
        dir_tick   = ticks;
        frame_tick = ft;
        respawn    = rs;
        @(posedge clk);
        #1;
        dir_tick   = 4'b0000;
        frame_tick = 1'b0;
        respawn    = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frameTicks(input int n);
        for (int i = 0; i < n; i++) applyStimulus(4'b0000, 1'b1, 1'b0);
    endtask

    int hops;

    initial begin
        reset      = 1'b1;
        enable     = 1'b1;
        frame_tick = 1'b0;
        dir_tick   = 4'b0000;
        dir_level  = 4'b0000;
        respawn    = 1'b0;
        init_x     = 10'd320;
        init_y     = 10'd448;
        idleCycles(2);
        reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("reset_pos_x", pos_x, 320);
        checkOutput("reset_pos_y", pos_y, 448);
        checkOutput("reset_direction", direction, 0);
        checkOutput("reset_moving", moving, 0);
        checkOutput("reset_hop_done", hop_done, 0);
        checkOutput("reset_reached_end", reached_end, 0);

        $display("[TB] single up hop");
        applyStimulus(K_UP, 1'b0, 1'b0);
        checkOutput("up_moving", moving, 1);
        checkOutput("up_direction", direction, 0);
        checkOutput("up_pos_y_before_tick", pos_y, 448);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(4'b0000, 1'b1, 1'b0);
            checkOutput("up_pos_y_step", pos_y, 448 - 4 * i);
        end
        checkOutput("up_hop_done_early", hop_done, 0);
        idleCycles(1);
        checkOutput("up_hop_done", hop_done, 1);
        checkOutput("up_moving_end", moving, 0);
        idleCycles(1);
        checkOutput("up_hop_done_once", hop_done, 0);
        checkOutput("up_pos_x", pos_x, 320);

        $display("[TB] edge turns");
        init_x = 10'd0;
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkOutput("edge_pos_x", pos_x, 0);
        applyStimulus(K_LEFT, 1'b0, 1'b0);
        checkOutput("edge_left_direction", direction, 2);
        checkOutput("edge_left_moving", moving, 0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("edge_left_pos_x", pos_x, 0);
        applyStimulus(K_DOWN, 1'b0, 1'b0);
        checkOutput("edge_down_direction", direction, 1);
        checkOutput("edge_down_moving", moving, 0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        checkOutput("edge_down_pos_y", pos_y, 448);
        init_x = 10'd320;
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkOutput("respawn_pos_x", pos_x, 320);
        checkOutput("respawn_direction", direction, 0);

        $display("[TB] buffered hop");
        applyStimulus(K_UP, 1'b0, 1'b0);
        frameTicks(2);
        applyStimulus(K_UP, 1'b0, 1'b0);
        frameTicks(1);
        applyStimulus(K_RIGHT, 1'b0, 1'b0);
        frameTicks(5);
        checkOutput("buf_pos_y_landed", pos_y, 416);
        idleCycles(1);
        checkOutput("buf_hop_done", hop_done, 1);
        checkOutput("buf_moving_across_landing", moving, 1);
        checkOutput("buf_direction", direction, 3);
        idleCycles(1);
        checkOutput("buf_moving_after", moving, 1);
        frameTicks(1);
        checkOutput("buf_pos_x_step", pos_x, 324);
        frameTicks(7);
        checkOutput("buf_pos_x_landed", pos_x, 352);
        idleCycles(1);
        checkOutput("buf_second_done", hop_done, 1);
        checkOutput("buf_no_extra_hop", moving, 0);
        checkOutput("buf_pos_y_final", pos_y, 416);

        $display("[TB] goal row");
        init_y = 10'd32;
        applyStimulus(4'b0000, 1'b0, 1'b1);
        idleCycles(1);
        checkOutput("goal_start_reached", reached_end, 0);
        applyStimulus(K_UP, 1'b0, 1'b0);
        frameTicks(8);
        checkOutput("goal_pos_y", pos_y, 0);
        checkOutput("goal_mid_hop", reached_end, 0);
        idleCycles(1);
        checkOutput("goal_landing_done", hop_done, 1);
        checkOutput("goal_landing_reached", reached_end, 0);
        idleCycles(1);
        checkOutput("goal_reached", reached_end, 1);
        applyStimulus(K_UP, 1'b0, 1'b0);
        checkOutput("goal_blocked_moving", moving, 0);
        checkOutput("goal_still_reached", reached_end, 1);
        init_y = 10'd448;
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkOutput("goal_respawn_clear", reached_end, 0);
        checkOutput("goal_respawn_pos_y", pos_y, 448);
        checkOutput("goal_respawn_pos_x", pos_x, 320);

        $display("[TB] respawn priority");
        applyStimulus(K_UP, 1'b1, 1'b1);
        checkOutput("prio_idle_moving", moving, 0);
        checkOutput("prio_idle_pos_y", pos_y, 448);
        applyStimulus(K_RIGHT, 1'b0, 1'b0);
        frameTicks(2);
        checkOutput("prio_mid_pos_x", pos_x, 328);
        applyStimulus(K_UP, 1'b1, 1'b1);
        checkOutput("prio_hop_pos_x", pos_x, 320);
        checkOutput("prio_hop_moving", moving, 0);
        checkOutput("prio_hop_direction", direction, 0);
        idleCycles(1);
        checkOutput("prio_no_hop_done", hop_done, 0);

        $display("[TB] enable gating");
        enable = 1'b0;
        applyStimulus(K_UP, 1'b0, 1'b0);
        checkOutput("dis_no_move", moving, 0);
        enable = 1'b1;
        applyStimulus(K_UP, 1'b0, 1'b0);
        applyStimulus(K_RIGHT, 1'b0, 1'b0);
        enable = 1'b0;
        frameTicks(1);
        checkOutput("dis_hop_continues", pos_y, 444);
        enable = 1'b1;
        frameTicks(7);
        idleCycles(1);
        checkOutput("dis_landed_done", hop_done, 1);
        checkOutput("dis_buffer_cleared", moving, 0);
        checkOutput("dis_direction", direction, 0);
        checkOutput("dis_pos_x", pos_x, 320);

`ifdef PLAYER_MOVER_REPEAT_EN
        $display("[TB] auto-repeat");
        applyStimulus(4'b0000, 1'b0, 1'b1);
        hops = 0;
        dir_level = K_UP;
        applyStimulus(K_UP, 1'b0, 1'b0);
        for (int t = 1; t <= 39; t++) begin
            applyStimulus(4'b0000, 1'b1, 1'b0);
            hops += int'(hop_done);
            for (int c = 0; c < 3; c++) begin
                idleCycles(1);
                hops += int'(hop_done);
            end
            if (t == 29) dir_level = 4'b0000;
        end
        checkOutput("repeat_hops", hops, 4);
        checkOutput("repeat_pos_y", pos_y, 320);
        checkOutput("repeat_idle", moving, 0);
`else
        $display("[TB] held level ignored");
        hops = 0;
        dir_level = K_UP;
        for (int t = 0; t < 15; t++) begin
            applyStimulus(4'b0000, 1'b1, 1'b0);
            hops += int'(moving);
        end
        dir_level = 4'b0000;
        checkOutput("level_no_move", hops, 0);
        checkOutput("level_pos_y", pos_y, 416);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
